efpga_fifo_push_arbiter: RTL and testbench
==========================================

Name: efpga_fifo_push_arbiter

Overview:
- Shares the single write port of an eFPGA-subsystem dual-port FIFO between NUM_REQ requesters using round-robin, burst-limited grants.
- Drives the FIFO push/wdata/flush inputs and watches its full flag.
- Sits between eFPGA/uDMA-side producers and the FIFO write side, in the FIFO write-clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 32, data width per requester and FIFO word width.
- MAX_BURST, 4, max beats per grant (>=1).
- CNT_W, $clog2(MAX_BURST+1), beat counter width (derived, do not override).

Ports:
- clk_i  input  1  clock; also the FIFO write clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_last_i  input  NUM_REQ  marks final beat of a requester's packet.
- req_data_i  input  NUM_REQ*WIDTH  packed data; requester k at [k*WIDTH +: WIDTH].
- req_ready_o  output  NUM_REQ  beat accepted when valid & ready.
- grant_o  output  NUM_REQ  one-hot current grant; all-zero when idle.
- fifo_full_i  input  1  FIFO full flag.
- fifo_push_o  output  1  FIFO push strobe.
- fifo_wdata_o  output  WIDTH  FIFO write data.
- flush_i  input  1  software flush request.
- fifo_flush_o  output  1  FIFO flush.
- busy_o  output  1  high while in GRANT state.

Behaviour:
- FSM: IDLE, GRANT. Registers: state, grant (one-hot), last_idx (rr pointer), beat_cnt.
- Reset values:
  - state=IDLE, grant=0, beat_cnt=0, last_idx=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0 during and after reset.
- IDLE:
  - If any req_valid_i, pick the first valid index scanning last_idx+1, last_idx+2, ... (mod NUM_REQ).
  - Register grant=onehot(idx), last_idx=idx, beat_cnt=0, and go to GRANT.
  - Arbitration latency is one cycle: valid at cycle N gives grant_o at N+1.
  - No push in IDLE.
- GRANT, with g the granted index:
  - req_ready_o[g] = ~fifo_full_i & ~flush_i. All other ready bits are 0.
  - fifo_push_o = req_valid_i[g] & ~fifo_full_i & ~flush_i (combinational).
  - fifo_wdata_o = req_data_i[g] when in GRANT, else 0.
  - A beat is counted when fifo_push_o=1; beat_cnt increments.
  - Release (return to IDLE, grant cleared next cycle) when either:
    - a beat occurs with req_last_i[g]=1, or
    - a beat occurs that brings beat_cnt to MAX_BURST, or
    - req_valid_i[g]=0 while not full.
  - After any release there is always one IDLE cycle before the next grant.
- Full: when fifo_full_i=1, the grant is held, no push, beat_cnt frozen. There is no timeout, and the stalled beat is not counted.
- Flush:
  - fifo_flush_o = flush_i (combinational pass-through).
  - During a flush cycle: no push, all ready bits 0.
  - Next state is IDLE, grant=0, beat_cnt=0; last_idx is kept, so round-robin continues after the flushed requester.
  - Flush while IDLE: state unchanged and no arbitration that cycle.
- Simultaneous release and new requests: handled by the mandatory IDLE cycle; the last_idx ordering gives fairness.
- Requester valid dropping in IDLE: has no effect, because arbitration samples the current cycle only.
- Reset mid-burst: immediate return to reset values, and the push strobe drops asynchronously.
- Assertions:
  - grant_o is onehot0.
  - fifo_push_o implies ~fifo_full_i.
  - beat_cnt <= MAX_BURST.

Test Plan:
- Single requester, burst limit: req0 valid continuously with 6 beats (D0..D5, last on D5), no full. Required:
  - grant_o=0001 at cycle 1; D0..D3 pushed in cycles 1-4.
  - IDLE at cycle 5; regrant at cycle 6; D4, D5 pushed in cycles 6-7.
  - IDLE at cycle 8; exactly 6 pushes in total.
- Round-robin: all 4 requesters continuously valid, no last. Required:
  - Grant order 0,1,2,3,0.
  - Each grant gets exactly 4 pushes, with one idle cycle between grants.
- Backpressure: fifo_full_i high for 3 cycles after the 2nd beat of req1. Required:
  - fifo_push_o=0 and req_ready_o=0 for those 3 cycles.
  - grant_o stays 0010; beats 3-4 follow; 4 beats in total.
- Early last: req2 asserts last on beat 2 while req3 is waiting. Required: req2 released after 2 pushes, then IDLE, then grant_o=1000.
- Flush mid-burst: flush_i pulsed on req1's beat 2. Required:
  - fifo_flush_o=1 that cycle, no push that cycle.
  - IDLE next cycle; next grant goes to req2, not req1.
- Async reset: rst_ni low for half a cycle mid-burst. Required:
  - grant_o=0 and fifo_push_o=0 immediately.
  - After release, the first grant goes to req0.

Source files
------------

// File: rtl/efpga_fifo_push_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// Grant/state are registered; push, ready and write data follow the current grant combinationally.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters (one cycle between grants)
// GRANT | one requester owns the FIFO write port until last/burst/valid-drop/flush
module efpga_fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_push_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  input  logic                     flush_i,
  output logic                     fifo_flush_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   last_idx;
  logic [CNT_W-1:0]   beat_cnt;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic               any_valid;
  logic [IDX_W-1:0]   next_idx;
  logic               in_grant;
  logic               port_open;
  logic               valid_g;
  logic               last_g;
  logic               push;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data_i[k*WIDTH +: WIDTH];
  end

  // Scan from the farthest offset down so the nearest valid index after last_idx wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    next_idx  = last_idx;
    any_valid = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand     = (int'(last_idx) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_valid_i[cand_idx]) begin
        next_idx  = cand_idx;
        any_valid = 1'b1;
      end
    end
  end

  // last_idx doubles as the granted index while in GRANT.
  assign in_grant  = (state == GRANT);
  assign port_open = ~fifo_full_i & ~flush_i;
  assign valid_g   = req_valid_i[last_idx];
  assign last_g    = req_last_i[last_idx];
  assign push      = in_grant & valid_g & port_open;

  assign fifo_push_o  = push;
  assign fifo_wdata_o = in_grant ? data_arr[last_idx] : '0;
  assign req_ready_o  = (in_grant && port_open) ? grant : '0;
  assign grant_o      = grant;
  assign busy_o       = in_grant;
  assign fifo_flush_o = flush_i & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      grant    <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush_i && any_valid) begin
            state    <= GRANT;
            grant    <= NUM_REQ'(1) << next_idx;
            last_idx <= next_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (flush_i) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
          end else if (push) begin
            if (last_g || beat_cnt == BURST_END) begin
              state    <= IDLE;
              grant    <= '0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end else if (!valid_g && !fifo_full_i) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_o));
  a_push_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_push_o |-> !fifo_full_i);
  a_beat_range:    assert property (@(posedge clk_i) disable iff (!rst_ni) beat_cnt <= BURST_MAX);
`endif

endmodule

// File: tb/tb_efpga_fifo_push_arbiter.sv
// Bench for efpga_fifo_push_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_efpga_fifo_push_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_last_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     fifo_full_i;
  logic                     fifo_push_o;
  logic [WIDTH-1:0]         fifo_wdata_o;
  logic                     flush_i;
  logic                     fifo_flush_o;
  logic                     busy_o;

  efpga_fifo_push_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o), .fifo_wdata_o(fifo_wdata_o),
    .flush_i(flush_i), .fifo_flush_o(fifo_flush_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  // Per-requester pending beats: {last, data}
  logic [WIDTH:0]   q [NUM_REQ][$];
  logic [WIDTH-1:0] push_log [$];
  int               pushes [NUM_REQ];
  logic             full, flush;
  logic [NUM_REQ-1:0] gate;

  // Reference model: owner, beats taken in this grant, round-robin pointer.
  bit m_busy;
  int m_g, m_cnt, m_ptr;

  logic [NUM_REQ-1:0] exp_grant, exp_ready, obs_grant, obs_ready;
  logic exp_push, exp_busy, exp_flush, obs_push, obs_busy, obs_flush;
  logic [WIDTH-1:0] exp_wdata, obs_wdata;
  logic [2*NUM_REQ+3+WIDTH-1:0] exp_vec, obs_vec;

  task automatic drive();
    logic [WIDTH:0] e;
    for (int k = 0; k < NUM_REQ; k++) begin
      e = (q[k].size() > 0) ? q[k][0] : '0;
      req_valid_i[k] = (q[k].size() > 0) && gate[k];
      req_last_i[k]  = e[WIDTH];
      req_data_i[k*WIDTH +: WIDTH] = e[WIDTH-1:0];
    end
    fifo_full_i = full;
    flush_i     = flush;
  endtask

  task automatic model_eval();
    exp_busy  = m_busy;
    exp_grant = m_busy ? NUM_REQ'(1 << m_g) : '0;
    exp_push  = m_busy && req_valid_i[m_g] && !fifo_full_i && !flush_i;
    exp_ready = (m_busy && !fifo_full_i && !flush_i) ? exp_grant : '0;
    exp_wdata = m_busy ? req_data_i[m_g*WIDTH +: WIDTH] : '0;
    exp_flush = flush_i;
    exp_vec   = {exp_grant, exp_ready, exp_push, exp_busy, exp_flush, exp_wdata};
  endtask

  task automatic model_tick();
    if (!m_busy) begin
      if (!flush_i) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          int c;
          c = (m_ptr + i) % NUM_REQ;
          if (!m_busy && req_valid_i[c]) begin
            m_busy = 1; m_g = c; m_ptr = c; m_cnt = 0;
          end
        end
      end
    end else if (flush_i) begin
      m_busy = 0;
    end else if (exp_push) begin
      m_cnt++;
      if (req_last_i[m_g] || m_cnt == MAX_BURST) m_busy = 0;
    end else if (!req_valid_i[m_g] && !fifo_full_i) begin
      m_busy = 0;
    end
  endtask

  // One clock: drive from queues, sample mid-cycle, retire modelled beats, advance the model.
  task automatic run_cycle();
    drive();
    #3;
    model_eval();
    obs_grant = grant_o; obs_ready = req_ready_o; obs_push = fifo_push_o;
    obs_busy = busy_o; obs_flush = fifo_flush_o; obs_wdata = fifo_wdata_o;
    obs_vec = {obs_grant, obs_ready, obs_push, obs_busy, obs_flush, obs_wdata};
    if (fifo_push_o === 1'b1) push_log.push_back(fifo_wdata_o);
    if (exp_push) begin
      void'(q[m_g].pop_front());
      pushes[m_g]++;
    end
    model_tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      q[k].delete();
      pushes[k] = 0;
    end
    push_log.delete();
    full = 0; flush = 0; gate = '1;
    drive();
    rst_ni = 0;
    #3;
    rst_ni = 1;
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = NUM_REQ - 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    req_valid_i = '1; req_last_i = '1; req_data_i = {4{32'hDEAD_BEEF}};
    fifo_full_i = 0; flush_i = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #4;
      total++;
      if ({grant_o, req_ready_o, fifo_push_o, busy_o, fifo_flush_o, fifo_wdata_o} !== '0)
        $display("FAIL reset_outputs got=%h/%h/%b/%b/%b/%h exp=all zero",
                 grant_o, req_ready_o, fifo_push_o, busy_o, fifo_flush_o, fifo_wdata_o);
      else passed++;
    end
    do_reset();
    run_cycle();
    total++;
    if (obs_vec !== '0 || exp_vec !== '0)
      $display("FAIL reset_idle got=%h exp=0", obs_vec);
    else passed++;
  endtask

  task automatic test_burst_limit();
    logic [9:0] pat;
    pat = 10'b0011011110;
    do_reset();
    for (int i = 0; i < 6; i++) q[0].push_back({(i == 5), 32'hA000_0000 + i});
    for (int c = 0; c < 10; c++) begin
      run_cycle();
      total++;
      if (obs_vec !== exp_vec) $display("FAIL burst_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_push !== pat[c] || obs_grant !== (pat[c] ? 4'b0001 : 4'b0000))
        $display("FAIL burst_plan c=%0d got push=%b grant=%b exp push=%b", c, obs_push, obs_grant, pat[c]);
      else passed++;
    end
    total++;
    if (push_log.size() != 6) $display("FAIL burst_count got=%0d exp=6", push_log.size());
    else passed++;
    for (int i = 0; i < push_log.size(); i++) begin
      total++;
      if (push_log[i] !== 32'hA000_0000 + i)
        $display("FAIL burst_data i=%0d got=%h exp=%h", i, push_log[i], 32'hA000_0000 + i);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 10; i++) q[k].push_back({1'b0, 32'hB000_0000 + k*256 + i});
    for (int c = 0; c < 25; c++) begin
      run_cycle();
      eg = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
      total++;
      if (obs_vec !== exp_vec) $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_grant !== eg || obs_push !== (c % 5 != 0))
        $display("FAIL rr_plan c=%0d got grant=%b push=%b exp grant=%b", c, obs_grant, obs_push, eg);
      else passed++;
    end
    total++;
    if (push_log.size() != 20) $display("FAIL rr_count got=%0d exp=20", push_log.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [9:0] pat;
    logic [3:0] eg, er;
    pat = 10'b0011000110;
    do_reset();
    for (int i = 0; i < 4; i++) q[1].push_back({(i == 3), 32'hC000_0000 + i});
    for (int c = 0; c < 10; c++) begin
      full = (c >= 3 && c <= 5);
      run_cycle();
      eg = (c >= 1 && c <= 7) ? 4'b0010 : 4'b0000;
      er = (c >= 1 && c <= 7 && !(c >= 3 && c <= 5)) ? 4'b0010 : 4'b0000;
      total++;
      if (obs_vec !== exp_vec) $display("FAIL bp_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_push !== pat[c] || obs_grant !== eg || obs_ready !== er)
        $display("FAIL bp_plan c=%0d got push=%b grant=%b ready=%b exp push=%b grant=%b ready=%b",
                 c, obs_push, obs_grant, obs_ready, pat[c], eg, er);
      else passed++;
    end
    full = 0;
    total++;
    if (push_log.size() != 4) $display("FAIL bp_count got=%0d exp=4", push_log.size());
    else passed++;
  endtask

  task automatic test_early_last();
    logic [3:0] gt [8];
    gt = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
    do_reset();
    for (int i = 0; i < 2; i++) q[2].push_back({(i == 1), 32'hE200_0000 + i});
    for (int i = 0; i < 3; i++) q[3].push_back({(i == 2), 32'hE300_0000 + i});
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      total++;
      if (obs_vec !== exp_vec) $display("FAIL last_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_grant !== gt[c]) $display("FAIL last_plan c=%0d got grant=%b exp=%b", c, obs_grant, gt[c]);
      else passed++;
    end
    total++;
    if (push_log.size() != 5 || push_log[1] !== 32'hE200_0001 || push_log[2] !== 32'hE300_0000)
      $display("FAIL last_data got count=%0d exp=5", push_log.size());
    else passed++;
  endtask

  task automatic test_flush();
    logic [3:0] gt [6];
    gt = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4};
    do_reset();
    for (int i = 0; i < 4; i++) q[1].push_back({(i == 3), 32'hF100_0000 + i});
    for (int i = 0; i < 4; i++) q[2].push_back({(i == 3), 32'hF200_0000 + i});
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2);
      run_cycle();
      total++;
      if (obs_vec !== exp_vec) $display("FAIL flush_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_grant !== gt[c]) $display("FAIL flush_grant c=%0d got=%b exp=%b", c, obs_grant, gt[c]);
      else passed++;
      if (c == 2) begin
        total++;
        if (obs_flush !== 1'b1 || obs_push !== 1'b0 || obs_ready !== 4'b0)
          $display("FAIL flush_cycle got flush=%b push=%b ready=%b exp 1/0/0000", obs_flush, obs_push, obs_ready);
        else passed++;
      end
    end
    flush = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) q[2].push_back({(i == 3), 32'h9200_0000 + i});
    run_cycle();
    drive();
    #3;
    total++;
    if (grant_o !== 4'b0100 || fifo_push_o !== 1'b1)
      $display("FAIL areset_pre got grant=%b push=%b exp 0100/1", grant_o, fifo_push_o);
    else passed++;
    rst_ni = 0;
    #1;
    total++;
    if (grant_o !== 4'b0 || fifo_push_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 4'b0)
      $display("FAIL areset_now got grant=%b push=%b busy=%b ready=%b exp zeros",
               grant_o, fifo_push_o, busy_o, req_ready_o);
    else passed++;
    for (int i = 0; i < 3; i++) q[0].push_back({(i == 2), 32'h9000_0000 + i});
    drive();
    #4;
    rst_ni = 1;
    m_busy = 0; m_cnt = 0; m_ptr = NUM_REQ - 1;
    model_eval();
    model_tick();
    @(posedge clk_i);
    #1;
    for (int c = 0; c < 2; c++) begin
      run_cycle();
      total++;
      if (obs_vec !== exp_vec) $display("FAIL areset_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
      total++;
      if (obs_grant !== 4'b0001) $display("FAIL areset_first c=%0d got grant=%b exp=0001", c, obs_grant);
      else passed++;
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) q[k].push_back({(i == len - 1), $urandom()});
        end
        gate[k] = ($urandom_range(0, 7) != 0);
      end
      full  = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 29) == 0);
      run_cycle();
      total++;
      if (obs_vec !== exp_vec) $display("FAIL rand_model c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      else passed++;
    end
    full = 0; flush = 0; gate = '1;
  endtask

  initial begin
    full = 0; flush = 0; gate = '1;
    req_valid_i = '0; req_last_i = '0; req_data_i = '0;
    fifo_full_i = 0; flush_i = 0;
    test_reset();
    test_burst_limit();
    test_round_robin();
    test_backpressure();
    test_early_last();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
